// File: rtl/rv32i_types.sv
// Shared RV32I types for the fetch/execute pipeline.
//   rv32i_opcode : 7-bit major opcode field of an RV32I instruction
//   btb_type_t   : control-flow class stored in a branch target buffer entry
package rv32i_types;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   typedef enum logic [1:0] {
      BTB_NONE = 2'd0,
      BTB_BR   = 2'd1,
      BTB_JAL  = 2'd2,
      BTB_JALR = 2'd3
   } btb_type_t;

   // Control-flow class of an opcode; BTB_NONE for anything that never redirects.
   function automatic btb_type_t btb_type_of(rv32i_opcode op);
      case (op)
         op_br:   return BTB_BR;
         op_jal:  return BTB_JAL;
         op_jalr: return BTB_JALR;
         default: return BTB_NONE;
      endcase
   endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree-PLRU helper for one set.
//   bits      in  current tree bits (heap order, node 0 = root)
//   touch_way in  way being marked most-recently used
//   next_bits out tree bits after the touch
//   victim    out least-recently-used way according to the current bits
// Each node bit names the subtree the victim walk descends into (0 = lower half).
// With s_way = 0 there is a single way: bits pass through and victim is 0.
module plru_tree #(
   parameter int unsigned s_way = 1,
   localparam int unsigned plru_w = (s_way > 0) ? (1 << s_way) - 1 : 1,
   localparam int unsigned way_w = (s_way > 0) ? s_way : 1
) (
   input  logic [plru_w-1:0] bits,
   input  logic [way_w-1:0]  touch_way,
   output logic [plru_w-1:0] next_bits,
   output logic [way_w-1:0]  victim
);

   int vic;
   int dir;

   always_comb begin
      next_bits = bits;
      vic = 0;
      dir = 0;
      // Touch: every node on the touched way's path points away from it.
      for (int lv = 0; lv < int'(s_way); lv++) begin
         for (int o = 0; o < (1 << lv); o++) begin
            if ((int'(touch_way) >> (int'(s_way) - lv)) == o) begin
               next_bits[(1 << lv) - 1 + o] =
                  (((int'(touch_way) >> (int'(s_way) - 1 - lv)) & 1) == 0);
            end
         end
      end
      // Victim: follow the node bits from the root down.
      for (int lv = 0; lv < int'(s_way); lv++) begin
         for (int o = 0; o < (1 << lv); o++) begin
            if (vic == o) dir = int'(bits[(1 << lv) - 1 + o]);
         end
         vic = vic * 2 + dir;
      end
      victim = vic[way_w-1:0];
   end

endmodule

// File: rtl/btb_assoc.sv
// N-way set-associative tagged branch target buffer for the fetch stage.
//   clk, rst            clock, synchronous active-high reset
//   predict_en          pipeline advance; gates all state changes except rst/flush
//   flush               invalidate every entry on the next edge
//   curr_pc, g_history  fetch-side lookup address and global history
//   resolved_pc, resolved_g_history, predictionFailed, expected_next_pc, EX_opcode
//                       EX-side resolve information used to install/refresh entries
//   predicted_target, btb_hit, hit_type
//                       combinational lookup result (0 / 0 / BTB_NONE on miss)
module btb_assoc
   import rv32i_types::*;
#(
   parameter int unsigned s_index    = 6,
   parameter int unsigned s_way      = 1,
   parameter int unsigned addr_start = 2,
   parameter int unsigned s_history  = 7,
   parameter bit          hash_en    = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 predict_en,
   input  logic                 flush,
   input  logic [31:0]          curr_pc,
   input  logic [s_history-1:0] g_history,
   input  logic [31:0]          resolved_pc,
   input  logic [s_history-1:0] resolved_g_history,
   input  logic                 predictionFailed,
   input  logic [31:0]          expected_next_pc,
   input  rv32i_opcode          EX_opcode,
   output logic [31:0]          predicted_target,
   output logic                 btb_hit,
   output btb_type_t            hit_type
);

   localparam int unsigned sets   = 1 << s_index;
   localparam int unsigned ways   = 1 << s_way;
   localparam int          tag_w  = 32 - int'(addr_start) - int'(s_index);
   localparam int unsigned plru_w = (s_way > 0) ? ways - 1 : 1;
   localparam int unsigned way_w  = (s_way > 0) ? s_way : 1;

   if (tag_w < 1) begin : g_tag_check
      $error("btb_assoc: tag width must be at least 1");
   end

   typedef struct packed {
      logic             valid;
      logic [tag_w-1:0] tag;
      logic [31:0]      target;
      btb_type_t        kind;
   } btb_entry_t;

   btb_entry_t        entry_q [sets][ways];
   logic [plru_w-1:0] plru_q  [sets];

   // History truncated to, or zero-extended up to, the index width.
   function automatic logic [s_index-1:0] fold_hist(logic [s_history-1:0] h);
      logic [31:0] hx;
      hx = 32'(h);
      return hx[s_index-1:0];
   endfunction

   logic [s_index-1:0] lk_idx, up_idx;
   logic [tag_w-1:0]   lk_tag, up_tag;

   assign lk_idx = curr_pc[addr_start +: s_index] ^ (hash_en ? fold_hist(g_history) : '0);
   assign up_idx = resolved_pc[addr_start +: s_index]
                 ^ (hash_en ? fold_hist(resolved_g_history) : '0);
   assign lk_tag = curr_pc[31 -: tag_w];
   assign up_tag = resolved_pc[31 -: tag_w];

   // Low PC bits and, without hashing, the history inputs are architecturally ignored.
   logic unused_inputs;
   assign unused_inputs = ^{curr_pc, resolved_pc, g_history, resolved_g_history};

   // Lookup: downward scan so the lowest matching way wins.
   logic             lk_hit;
   logic [way_w-1:0] lk_way;
   logic [31:0]      lk_target;
   btb_type_t        lk_kind;

   always_comb begin
      lk_hit    = 1'b0;
      lk_way    = '0;
      lk_target = '0;
      lk_kind   = BTB_NONE;
      for (int w = int'(ways) - 1; w >= 0; w--) begin
         if (entry_q[lk_idx][w].valid && entry_q[lk_idx][w].tag == lk_tag) begin
            lk_hit    = 1'b1;
            lk_way    = w[way_w-1:0];
            lk_target = entry_q[lk_idx][w].target;
            lk_kind   = entry_q[lk_idx][w].kind;
         end
      end
   end

   assign btb_hit          = lk_hit;
   assign predicted_target = lk_target;
   assign hit_type         = lk_kind;

   // Update: way selection is tag hit, then lowest invalid way, then PLRU victim.
   logic             up_ok, up_hit, inv_found;
   logic [way_w-1:0] up_hit_way, inv_way, victim_way, wr_way;

   assign up_ok = predictionFailed && predict_en
               && (EX_opcode == op_br || EX_opcode == op_jal || EX_opcode == op_jalr);

   always_comb begin
      up_hit     = 1'b0;
      up_hit_way = '0;
      inv_found  = 1'b0;
      inv_way    = '0;
      for (int w = int'(ways) - 1; w >= 0; w--) begin
         if (entry_q[up_idx][w].valid && entry_q[up_idx][w].tag == up_tag) begin
            up_hit     = 1'b1;
            up_hit_way = w[way_w-1:0];
         end
         if (!entry_q[up_idx][w].valid) begin
            inv_found = 1'b1;
            inv_way   = w[way_w-1:0];
         end
      end
      if (up_hit)         wr_way = up_hit_way;
      else if (inv_found) wr_way = inv_way;
      else                wr_way = victim_way;
   end

   logic [plru_w-1:0] lk_plru_next, up_plru_next;
   logic [way_w-1:0]  unused_lk_victim;

   plru_tree #(.s_way(s_way)) u_plru_lookup (
      .bits      (plru_q[lk_idx]),
      .touch_way (lk_way),
      .next_bits (lk_plru_next),
      .victim    (unused_lk_victim)
   );

   plru_tree #(.s_way(s_way)) u_plru_update (
      .bits      (plru_q[up_idx]),
      .touch_way (wr_way),
      .next_bits (up_plru_next),
      .victim    (victim_way)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < int'(sets); s++) begin
            plru_q[s] <= '0;
            for (int w = 0; w < int'(ways); w++) entry_q[s][w] <= '0;
         end
      end else if (flush) begin
         for (int s = 0; s < int'(sets); s++) begin
            for (int w = 0; w < int'(ways); w++) entry_q[s][w].valid <= 1'b0;
         end
      end else if (predict_en) begin
         if (lk_hit) plru_q[lk_idx] <= lk_plru_next;
         // Issued after the lookup touch so the update wins on a shared set.
         if (up_ok) begin
            entry_q[up_idx][wr_way] <= '{valid:  1'b1,
                                         tag:    up_tag,
                                         target: expected_next_pc,
                                         kind:   btb_type_of(EX_opcode)};
            plru_q[up_idx] <= up_plru_next;
         end
      end
   end

endmodule
